// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler that time-shares one 1-bit full-adder
// cell between two requesters. Each add takes WIDTH cycles, LSB first. The
// result is presented with a one-cycle done pulse tagged by requester ID.
module serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] opa_reg, opb_reg, acc_reg;
   logic             carry_reg;
   logic [CW-1:0]    count_reg;
   logic             cur_id_reg, last_id_reg;

   logic             grant_go, grant_id;
   logic             last_bit;
   logic             ha0_s, ha0_c, ha1_s, ha1_c;
   logic             carry_next;
   logic [WIDTH-1:0] acc_next;

   // Shared full-adder cell: two half adders plus an OR on the carries.
   always_comb begin
      ha0_s      = opa_reg[0] ^ opb_reg[0];
      ha0_c      = opa_reg[0] & opb_reg[0];
      ha1_s      = ha0_s ^ carry_reg;
      ha1_c      = ha0_s & carry_reg;
      carry_next = ha0_c | ha1_c;
      acc_next   = {ha1_s, acc_reg[WIDTH-1:1]};
      last_bit   = (count_reg == CW'(WIDTH - 1));
   end

   // Next-state and arbitration: a tie goes to the requester not served last.
   always_comb begin
      state_next = state_reg;
      grant_go   = 1'b0;
      grant_id   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               grant_go   = 1'b1;
               grant_id   = (req0 && req1) ? ~last_id_reg : req1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_bit) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Operand capture, bit-serial stepping and result/pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_reg     <= '0;
         opb_reg     <= '0;
         acc_reg     <= '0;
         carry_reg   <= 1'b0;
         count_reg   <= '0;
         cur_id_reg  <= 1'b0;
         last_id_reg <= 1'b1;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         done_id     <= 1'b0;
         sum         <= '0;
         cout        <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         done <= 1'b0;
         if (grant_go) begin
            opa_reg     <= grant_id ? a1 : a0;
            opb_reg     <= grant_id ? b1 : b0;
            carry_reg   <= 1'b0;
            count_reg   <= '0;
            cur_id_reg  <= grant_id;
            last_id_reg <= grant_id;
            ack0        <= ~grant_id;
            ack1        <= grant_id;
            busy        <= 1'b1;
         end else if (state_reg == RUN) begin
            carry_reg <= carry_next;
            acc_reg   <= acc_next;
            opa_reg   <= opa_reg >> 1;
            opb_reg   <= opb_reg >> 1;
            count_reg <= count_reg + CW'(1);
            if (last_bit) begin
               sum     <= acc_next;
               cout    <= carry_next;
               done_id <= cur_id_reg;
               done    <= 1'b1;
               busy    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched (WIDTH=8): scoreboard of expected
// results pushed at grant time, popped by a monitor on every done pulse.
module tb_serial_add_sched;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         ack0, ack1, busy, done, done_id, cout;
   logic [W-1:0] sum;

   typedef struct packed {
      logic         id;
      logic         cout;
      logic [W-1:0] sum;
   } exp_t;

   exp_t         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   bit           tb_last_id = 1'b1;
   logic [W-1:0] cur_a[2];
   logic [W-1:0] cur_b[2];

   serial_add_sched #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
      .done_id(done_id), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_ops(input bit id, input logic [W-1:0] x, input logic [W-1:0] y);
      cur_a[id] = x;
      cur_b[id] = y;
      if (id) begin a1 = x; b1 = y; end
      else    begin a0 = x; b0 = y; end
   endtask

   // Called at the negedge where the ack of requester id must be visible.
   task automatic run_one(input bit id, input bit reraise, input bit late1);
      logic [W:0] s;
      int         busy_cnt;
      s = {1'b0, cur_a[id]} + {1'b0, cur_b[id]};
      exp_q.push_back('{id: id, cout: s[W], sum: s[W-1:0]});
      check_val(id ? "ack1" : "ack0", id ? ack1 : ack0, 1);
      check_val("ack_other", id ? ack0 : ack1, 0);
      if (id) req1 = 1'b0; else req0 = 1'b0;
      busy_cnt = busy ? 1 : 0;
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         if (reraise && k == 1) begin
            set_ops(id, W'($urandom), W'($urandom));
            if (id) req1 = 1'b1; else req0 = 1'b1;
         end
         if (late1 && k == 4) begin
            set_ops(1'b1, W'($urandom), W'($urandom));
            req1 = 1'b1;
         end
         if (busy) busy_cnt++;
         check_val("no_ack_in_run", ack0 | ack1, 0);
      end
      check_val("done_latency", done, 1);
      check_val("busy_cycles", busy_cnt, W);
      $display("op id=%0d a=%02h b=%02h -> exp %03h", id, cur_a[id], cur_b[id], s);
   endtask

   // Start at a negedge; drive requests and follow each grant to its done.
   task automatic do_op(input bit r0, input bit r1, input bit late1,
                        input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1);
      bit first;
      set_ops(1'b0, x0, y0);
      set_ops(1'b1, x1, y1);
      req0 = r0;
      req1 = r1;
      first = (r0 && r1) ? ~tb_last_id : r1;
      @(negedge clk);
      run_one(first, 1'b0, late1);
      tb_last_id = first;
      if ((r0 && r1) || late1) begin
         @(negedge clk);
         run_one(~first, 1'b0, 1'b0);
         tb_last_id = ~first;
      end
   endtask

   // Both requesters held; each drops for one cycle after its ack.
   task automatic hold_both(input int n);
      bit cur;
      set_ops(1'b0, W'($urandom), W'($urandom));
      set_ops(1'b1, W'($urandom), W'($urandom));
      req0 = 1'b1;
      req1 = 1'b1;
      cur = ~tb_last_id;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         run_one(cur, i < n - 2, 1'b0);
         tb_last_id = cur;
         cur = ~cur;
      end
   endtask

   // Monitor: pop the scoreboard on done, watch pulse exclusivity.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ack0 | ack1) check_val("ack_excl", ack0 & ack1, 0);
         if (done) begin
            check_val("done_vs_ack", ack0 | ack1, 0);
            if (exp_q.size() == 0) begin
               check_val("done_unexpected", done, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_val("done_id", done_id, e.id);
               check_val("sum", sum, e.sum);
               check_val("cout", cout, e.cout);
               $display("done id=%0d sum=%02h cout=%0d", done_id, sum, cout);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (3) @(negedge clk);
      check_val("rst_ack0", ack0, 0);
      check_val("rst_ack1", ack1, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_done_id", done_id, 0);
      check_val("rst_sum", sum, 0);
      check_val("rst_cout", cout, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed single adds.
      do_op(1'b1, 1'b0, 1'b0, 8'h5A, 8'h3C, 8'h00, 8'h00);
      check_val("t1_sum", sum, 8'h96);
      do_op(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h01);
      check_val("t2_sum", sum, 8'h00);
      check_val("t2_cout", cout, 1);

      // Continuous contention: alternating grants.
      hold_both(4);

      // req1 arrives mid-run of a req0 add.
      do_op(1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 8'h00, 8'h00);

      // Reset pulsed mid-run at bit 4 of 0xAA+0x55.
      set_ops(1'b0, 8'hAA, 8'h55);
      req0 = 1'b1;
      @(negedge clk);
      check_val("rst_run_ack0", ack0, 1);
      req0 = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_done", done, 0);
      check_val("mid_rst_sum", sum, 0);
      check_val("mid_rst_cout", cout, 0);
      check_val("mid_rst_acks", {ack0, ack1}, 0);
      check_val("mid_rst_done_id", done_id, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tb_last_id = 1'b1;
      do_op(1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04);

      // Random sweep over both requesters, including ties.
      for (int i = 0; i < 1000; i++) begin
         int mode;
         mode = $urandom_range(0, 2);
         do_op(mode != 1, mode != 0, 1'b0,
               W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      end

      repeat (3) @(negedge clk);
      check_val("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
